// File: rtl/inst_buffer_pkg.sv
// Shared frontend defines for the instruction buffer: sizing defaults and the
// storage entry layout.
package inst_buffer_pkg;

  localparam int IBUF_SIZE       = 32;
  localparam int BLOCK_INST_SIZE = 8;
  localparam int FETCH_WIDTH     = 4;
  localparam int FSQ_WIDTH       = 6;
  localparam int INST_W          = 32;

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [FSQ_WIDTH-1:0] fsq;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction buffer between predecode and decode: accepts up to
// BLOCK_INST_SIZE instructions per cycle and presents up to FETCH_WIDTH in order.
module inst_buffer #(
  parameter int DEPTH           = inst_buffer_pkg::IBUF_SIZE,
  parameter int BLOCK_INST_SIZE = inst_buffer_pkg::BLOCK_INST_SIZE,
  parameter int FETCH_WIDTH     = inst_buffer_pkg::FETCH_WIDTH
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [BLOCK_INST_SIZE-1:0]                          in_en,
  input  logic [$clog2(BLOCK_INST_SIZE):0]                    in_num,
  input  logic [BLOCK_INST_SIZE-1:0][31:0]                    in_inst,
  input  logic [inst_buffer_pkg::FSQ_WIDTH-1:0]               in_fsqIdx,
  input  logic                                                flush,
  input  logic                                                stall,
  output logic                                                full,
  output logic [FETCH_WIDTH-1:0]                              out_en,
  output logic [FETCH_WIDTH-1:0][31:0]                        out_inst,
  output logic [FETCH_WIDTH-1:0][inst_buffer_pkg::FSQ_WIDTH-1:0] out_fsqIdx
);
  import inst_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_W = $clog2(BLOCK_INST_SIZE) + 1;

  ibuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             wr_fire;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] wnum;
  logic [CNT_W-1:0] rnum;

  // Full is judged against a whole block so upstream never has to split one.
  always_comb begin
    free_cnt = CNT_W'(DEPTH) - count;
    full     = free_cnt < CNT_W'(BLOCK_INST_SIZE);
    wr_fire  = (|in_en) && !full && !flush;
    wnum     = wr_fire ? CNT_W'(in_num) : '0;
    rnum     = (count < CNT_W'(FETCH_WIDTH)) ? count : CNT_W'(FETCH_WIDTH);
    if (stall || flush) begin
      rnum = '0;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every reader
  // sees the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + rnum[PTR_W-1:0];
      tail  <= tail + wnum[PTR_W-1:0];
      count <= count + wnum - rnum;
    end
  end

  // NOTE: the storage array has no reset; an entry is only observable once
  // count covers it, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
        if (NUM_W'(i) < in_num) begin
          mem[tail + PTR_W'(i)] <= '{inst: in_inst[i], fsq: in_fsqIdx};
        end
      end
    end
  end

  // Lanes read straight from storage; pointer arithmetic wraps at DEPTH.
  always_comb begin
    out_en     = '0;
    out_inst   = '0;
    out_fsqIdx = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_en[i]     = !flush && (count > CNT_W'(i));
      out_inst[i]   = mem[head + PTR_W'(i)].inst;
      out_fsqIdx[i] = mem[head + PTR_W'(i)].fsq;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_inst_buffer;

  localparam int DEPTH = 32;
  localparam int B     = 8;
  localparam int FW    = 4;
  localparam int FSQ   = 6;
  localparam int NUM_W = $clog2(B) + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [B-1:0]            in_en = '0;
  logic [NUM_W-1:0]        in_num = '0;
  logic [B-1:0][31:0]      in_inst = '0;
  logic [FSQ-1:0]          in_fsqIdx = '0;
  logic                    flush = 1'b0;
  logic                    stall = 1'b0;
  logic                    full;
  logic [FW-1:0]           out_en;
  logic [FW-1:0][31:0]     out_inst;
  logic [FW-1:0][FSQ-1:0]  out_fsqIdx;

  inst_buffer #(.DEPTH(DEPTH), .BLOCK_INST_SIZE(B), .FETCH_WIDTH(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_num     (in_num),
    .in_inst    (in_inst),
    .in_fsqIdx  (in_fsqIdx),
    .flush      (flush),
    .stall      (stall),
    .full       (full),
    .out_en     (out_en),
    .out_inst   (out_inst),
    .out_fsqIdx (out_fsqIdx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]    inst;
    logic [FSQ-1:0] fsq;
  } ment_t;

  typedef struct packed {
    logic [FW-1:0]          en;
    logic                   full;
    logic [FW-1:0][31:0]    inst;
    logic [FW-1:0][FSQ-1:0] fsq;
  } exp_t;

  ment_t m_q[$];     // reference contents, oldest first
  exp_t  exp_q[$];   // expected outputs, one per driven cycle
  exp_t  mon_e;
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, record what the DUT must show during it, then
  // advance the model to the state after the coming edge.
  task automatic drive(input int num, input bit fl, input bit st);
    exp_t e;
    int   rd;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_num    = num[NUM_W-1:0];
    in_en     = B'((1 << num) - 1);
    in_fsqIdx = FSQ'($urandom);
    for (int i = 0; i < B; i++) in_inst[i] = $urandom;
    flush = fl;
    stall = st;

    e = '0;
    e.full = (DEPTH - m_q.size()) < B;
    for (int i = 0; i < FW; i++) begin
      if (!fl && i < m_q.size()) begin
        e.en[i]   = 1'b1;
        e.inst[i] = m_q[i].inst;
        e.fsq[i]  = m_q[i].fsq;
      end
    end
    exp_q.push_back(e);

    if (fl) begin
      m_q.delete();
    end else begin
      if (!st) begin
        rd = (m_q.size() < FW) ? m_q.size() : FW;
        repeat (rd) void'(m_q.pop_front());
      end
      if (num > 0 && !e.full) begin
        for (int i = 0; i < num; i++) m_q.push_back('{inst: in_inst[i], fsq: in_fsqIdx});
      end
    end
  endtask

  task automatic idle(input int n, input bit st);
    repeat (n) drive(0, 1'b0, st);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst out_en", 64'(out_en), 64'(0));
    check("async_rst full", 64'(full), 64'(0));
    m_q.delete();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("out_en", 64'(out_en), 64'(mon_e.en));
      check("full", 64'(full), 64'(mon_e.full));
      for (int i = 0; i < FW; i++) begin
        if (mon_e.en[i]) begin
          check($sformatf("out_inst[%0d]", i), 64'(out_inst[i]), 64'(mon_e.inst[i]));
          check($sformatf("out_fsqIdx[%0d]", i), 64'(out_fsqIdx[i]), 64'(mon_e.fsq[i]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check("reset out_en", 64'(out_en), 64'(0));
    check("reset full", 64'(full), 64'(0));

    // Single block on an empty buffer, drained over two cycles.
    drive(8, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Fill to full under stall; the fifth block must be dropped.
    repeat (4) drive(8, 1'b0, 1'b1);
    drive(8, 1'b0, 1'b1);
    idle(9, 1'b0);

    // Simultaneous enqueue and dequeue from count=6.
    drive(6, 1'b0, 1'b1);
    drive(5, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Park both pointers at 28, then write a block straddling the wrap.
    async_reset();
    repeat (4) drive(7, 1'b0, 1'b1);
    idle(7, 1'b0);
    drive(8, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Flush with a concurrent write at count=20.
    drive(8, 1'b0, 1'b1);
    drive(8, 1'b0, 1'b1);
    drive(4, 1'b0, 1'b1);
    drive(8, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Asynchronous reset with count=12, then confirm nothing stale reappears.
    drive(8, 1'b0, 1'b1);
    drive(4, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1);
    async_reset();
    idle(2, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, B), $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #1;
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
